// File: rtl/regbank_mp.sv
// regbank_mp: multi-ported physical register file with a ready scoreboard.
// Every read, write-back and invalidate port is accepted on every cycle.
// Reads are registered. With BYPASS=1 a read returns the state that exists
// after this cycle's updates. With BYPASS=0 it returns the state before them.

// One read lane: registers the table entry selected by its address.
module regbank_mp_rd #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 7
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [AWIDTH-1:0]                     addr,
    input  logic [(2**AWIDTH)-1:0][DWIDTH-1:0]    tbl_data,
    input  logic [(2**AWIDTH)-1:0]                tbl_vld,
    output logic [DWIDTH-1:0]                     rd_data,
    output logic                                  rd_valid
);

    // Operand capture; reset clears both data and valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_data  <= tbl_data[addr];
            rd_valid <= tbl_vld[addr];
        end
    end

endmodule

module regbank_mp #(
    parameter int DWIDTH     = 32,
    parameter int AWIDTH     = 7,
    parameter int READ_PORT  = 4,
    parameter int WRITE_PORT = 2,
    parameter int INV_PORT   = 1,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [WRITE_PORT-1:0]                 write_en,
    input  logic [WRITE_PORT-1:0][AWIDTH-1:0]     write_address,
    input  logic [WRITE_PORT-1:0][DWIDTH-1:0]     write_data,
    input  logic [INV_PORT-1:0]                   invalidate_en,
    input  logic [INV_PORT-1:0][AWIDTH-1:0]       invalidate_register,
    input  logic [READ_PORT-1:0][AWIDTH-1:0]      read_addr,
    output logic [READ_PORT-1:0][DWIDTH-1:0]      read_data,
    output logic [READ_PORT-1:0]                  read_valid,
    output logic [(2**AWIDTH)-1:0]                register_valid,
    output logic                                  write_conflict
);

    localparam int DEPTH = 2**AWIDTH;

    logic [DEPTH-1:0][DWIDTH-1:0] mem, mem_nxt;
    logic [DEPTH-1:0]             vld, vld_nxt;
    logic                         conflict_nxt;
    logic [DEPTH-1:0][DWIDTH-1:0] tbl_data;
    logic [DEPTH-1:0]             tbl_vld;

    // Post-update state. Later write ports override earlier ones. Invalidates
    // are applied last so that they beat a write to the same register.
    // Entry 0 is never touched, so it keeps its reset value of 0 and valid.
    always_comb begin
        mem_nxt = mem;
        vld_nxt = vld;
        for (int w = 0; w < WRITE_PORT; w++) begin
            if (write_en[w] && (write_address[w] != '0)) begin
                mem_nxt[write_address[w]] = write_data[w];
                vld_nxt[write_address[w]] = 1'b1;
            end
        end
        for (int i = 0; i < INV_PORT; i++) begin
            if (invalidate_en[i] && (invalidate_register[i] != '0)) begin
                vld_nxt[invalidate_register[i]] = 1'b0;
            end
        end
    end

    // Flags two enabled write ports that target the same nonzero register.
    always_comb begin
        conflict_nxt = 1'b0;
        for (int a = 0; a < WRITE_PORT; a++) begin
            for (int b = a + 1; b < WRITE_PORT; b++) begin
                if (write_en[a] && write_en[b] &&
                    (write_address[a] == write_address[b]) &&
                    (write_address[a] != '0)) begin
                    conflict_nxt = 1'b1;
                end
            end
        end
    end

    // Storage and scoreboard. Reset leaves every register at 0 and ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem            <= '0;
            vld            <= '1;
            write_conflict <= 1'b0;
        end else begin
            mem            <= mem_nxt;
            vld            <= vld_nxt;
            write_conflict <= conflict_nxt;
        end
    end

    assign register_valid = {vld[DEPTH-1:1], 1'b1};

    // Write-first lanes read the post-update view. Read-first lanes read the stored view.
    assign tbl_data = BYPASS ? mem_nxt : mem;
    assign tbl_vld  = BYPASS ? vld_nxt : vld;

    genvar r;
    generate
        for (r = 0; r < READ_PORT; r++) begin : g_rd
            regbank_mp_rd #(
                .DWIDTH (DWIDTH),
                .AWIDTH (AWIDTH)
            ) u_rd (
                .clk      (clk),
                .reset    (reset),
                .addr     (read_addr[r]),
                .tbl_data (tbl_data),
                .tbl_vld  (tbl_vld),
                .rd_data  (read_data[r]),
                .rd_valid (read_valid[r])
            );
        end
    endgenerate

endmodule

// File: tb/tb_regbank_mp.sv
// Directed checks of regbank_mp in write-first (d1) and read-first (d0) builds.
// A short random soak against a behavioural model follows the directed checks.
module tb_regbank_mp;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [1:0]           wen;
    logic [1:0][6:0]      waddr;
    logic [1:0][31:0]     wdata;
    logic [0:0]           ien;
    logic [0:0][6:0]      ireg;
    logic [3:0][6:0]      raddr;
    logic [3:0][31:0]     rd1, rd0;
    logic [3:0]           rv1, rv0;
    logic [127:0]         reg1, reg0;
    logic                 wc1, wc0;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model used by the soak.
    logic [31:0]  m_mem [128];
    logic [127:0] m_vld;
    logic [31:0]  n_mem [128];
    logic [127:0] n_vld;
    logic [3:0][31:0] e_rd1, e_rd0;
    logic [3:0]       e_rv1, e_rv0;
    logic             e_wc;

    always #5 clk = ~clk;

    regbank_mp #(.BYPASS(1'b1)) d1 (
        .clk(clk), .reset(rst_n), .write_en(wen), .write_address(waddr),
        .write_data(wdata), .invalidate_en(ien), .invalidate_register(ireg),
        .read_addr(raddr), .read_data(rd1), .read_valid(rv1),
        .register_valid(reg1), .write_conflict(wc1)
    );

    regbank_mp #(.BYPASS(1'b0)) d0 (
        .clk(clk), .reset(rst_n), .write_en(wen), .write_address(waddr),
        .write_data(wdata), .invalidate_en(ien), .invalidate_register(ireg),
        .read_addr(raddr), .read_data(rd0), .read_valid(rv0),
        .register_valid(reg0), .write_conflict(wc0)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen = '0; waddr = '0; wdata = '0; ien = '0; ireg = '0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_rd1"}, rd1, '0);
        chk({tag, "_rd0"}, rd0, '0);
        chk({tag, "_rv1"}, {124'd0, rv1}, 128'h0);
        chk({tag, "_rv0"}, {124'd0, rv0}, 128'h0);
        chk({tag, "_reg1"}, reg1, {128{1'b1}});
        chk({tag, "_reg0"}, reg0, {128{1'b1}});
        chk({tag, "_wc"}, {126'd0, wc1, wc0}, 128'h0);
    endtask

    initial begin
        idle();
        raddr = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #2 chk_reset_state("rst_init");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Reads after reset: zero data, all ready.
        raddr[0] = 7'd0; raddr[1] = 7'd5; raddr[2] = 7'd127; raddr[3] = 7'd64;
        step();
        chk("rd_after_rst_data", rd1, '0);
        chk("rd_after_rst_valid", {124'd0, rv1}, 128'hF);
        chk("rd_after_rst_reg", reg1, {128{1'b1}});
        raddr = '0;

        // Invalidate reg 10, then write it from port 1 three cycles later.
        ien[0] = 1'b1; ireg[0] = 7'd10;
        step(); idle();
        chk("inv10_t1", {127'd0, reg1[10]}, 128'h0);
        step();
        chk("inv10_t2", {127'd0, reg1[10]}, 128'h0);
        step();
        chk("inv10_t3", {127'd0, reg0[10]}, 128'h0);
        wen[1] = 1'b1; waddr[1] = 7'd10; wdata[1] = 32'hDEADBEEF;
        step(); idle();
        chk("inv10_t4", {127'd0, reg1[10]}, 128'h1);
        raddr[0] = 7'd10;
        step();
        chk("rd10_d1_data", {96'd0, rd1[0]}, 128'hDEADBEEF);
        chk("rd10_d0_data", {96'd0, rd0[0]}, 128'hDEADBEEF);
        chk("rd10_valid", {126'd0, rv1[0], rv0[0]}, 128'h3);

        // Same-cycle write and read of reg 20.
        wen[0] = 1'b1; waddr[0] = 7'd20; wdata[0] = 32'h12345678; raddr[0] = 7'd20;
        step(); idle();
        chk("byp20_d1_data", {96'd0, rd1[0]}, 128'h12345678);
        chk("byp20_d1_valid", {127'd0, rv1[0]}, 128'h1);
        chk("byp20_d0_old", {96'd0, rd0[0]}, 128'h0);
        chk("byp20_d0_valid", {127'd0, rv0[0]}, 128'h1);
        step();
        chk("byp20_d0_new", {96'd0, rd0[0]}, 128'h12345678);

        // Two ports write reg 33: the higher port wins and a conflict is flagged.
        wen = 2'b11; waddr[0] = 7'd33; waddr[1] = 7'd33; wdata[0] = 32'h1; wdata[1] = 32'h2;
        step(); idle();
        chk("conf33_pulse", {126'd0, wc1, wc0}, 128'h3);
        raddr[0] = 7'd33;
        step();
        chk("conf33_clear", {126'd0, wc1, wc0}, 128'h0);
        chk("conf33_data_d1", {96'd0, rd1[0]}, 128'h2);
        chk("conf33_data_d0", {96'd0, rd0[0]}, 128'h2);
        wen = 2'b11; waddr[0] = 7'd0; waddr[1] = 7'd0; wdata[0] = 32'h55; wdata[1] = 32'h66;
        raddr[0] = 7'd0;
        step(); idle();
        chk("reg0_no_conf", {127'd0, wc1}, 128'h0);
        chk("reg0_reads0", {96'd0, rd1[0]}, 128'h0);
        chk("reg0_valid", {127'd0, rv1[0]}, 128'h1);

        // Invalidate and write reg 40 in the same cycle.
        ien[0] = 1'b1; ireg[0] = 7'd40;
        wen[0] = 1'b1; waddr[0] = 7'd40; wdata[0] = 32'h0000A5A5; raddr[1] = 7'd40;
        step(); idle();
        chk("iw40_reg", {127'd0, reg1[40]}, 128'h0);
        chk("iw40_d1_data", {96'd0, rd1[1]}, 128'hA5A5);
        chk("iw40_d1_valid", {127'd0, rv1[1]}, 128'h0);
        chk("iw40_d0_data", {96'd0, rd0[1]}, 128'h0);
        chk("iw40_d0_valid", {127'd0, rv0[1]}, 128'h1);
        step();
        chk("iw40_d0_data2", {96'd0, rd0[1]}, 128'hA5A5);
        chk("iw40_d0_valid2", {127'd0, rv0[1]}, 128'h0);
        ien[0] = 1'b1; ireg[0] = 7'd0;
        step(); idle();
        chk("inv0_reg1", reg1, ~(128'd1 << 40));
        chk("inv0_reg0", reg0, ~(128'd1 << 40));

        // Reset mid-run while a write is in flight.
        wen[0] = 1'b1; waddr[0] = 7'd50; wdata[0] = 32'hCAFEF00D; raddr[2] = 7'd50;
        step();
        rst_n = 1'b0;
        #1 chk_reset_state("rst_mid");
        @(posedge clk); @(negedge clk);
        idle();
        rst_n = 1'b1;
        raddr[0] = 7'd33; raddr[1] = 7'd40; raddr[2] = 7'd50; raddr[3] = 7'd10;
        step();
        chk("post_rst_data", rd1, '0);
        chk("post_rst_valid", {124'd0, rv1}, 128'hF);
        chk("post_rst_reg", reg1, {128{1'b1}});

        // Random soak over a narrow address range to provoke collisions.
        for (int a = 0; a < 128; a++) m_mem[a] = '0;
        m_vld = {128{1'b1}};
        for (int c = 0; c < 2000; c++) begin
            for (int w = 0; w < 2; w++) begin
                wen[w]   = 1'($urandom_range(0, 1));
                waddr[w] = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 7));
                wdata[w] = $urandom;
            end
            ien[0]  = ($urandom_range(0, 3) == 0);
            ireg[0] = 7'($urandom_range(0, 7));
            for (int r = 0; r < 4; r++) raddr[r] = 7'($urandom_range(0, 7));

            for (int a = 0; a < 128; a++) n_mem[a] = m_mem[a];
            n_vld = m_vld;
            for (int w = 0; w < 2; w++) begin
                if (wen[w] && waddr[w] != 0) begin
                    n_mem[waddr[w]] = wdata[w];
                    n_vld[waddr[w]] = 1'b1;
                end
            end
            if (ien[0] && ireg[0] != 0) n_vld[ireg[0]] = 1'b0;
            e_wc = wen[0] && wen[1] && (waddr[0] == waddr[1]) && (waddr[0] != 0);
            for (int r = 0; r < 4; r++) begin
                e_rd1[r] = n_mem[raddr[r]];
                e_rv1[r] = n_vld[raddr[r]];
                e_rd0[r] = m_mem[raddr[r]];
                e_rv0[r] = m_vld[raddr[r]];
            end

            step();
            chk("soak_rd1", rd1, e_rd1);
            chk("soak_rv1", {124'd0, rv1}, {124'd0, e_rv1});
            chk("soak_rd0", rd0, e_rd0);
            chk("soak_rv0", {124'd0, rv0}, {124'd0, e_rv0});
            chk("soak_reg", reg1, n_vld);
            chk("soak_wc", {126'd0, wc1, wc0}, {126'd0, e_wc, e_wc});

            for (int a = 0; a < 128; a++) m_mem[a] = n_mem[a];
            m_vld = n_vld;
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
